// File: rtl/multi_axis_stepper_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_axis_stepper_ctrl
// Description : N-channel stepper axis controller. Homes each axis against
//               its Stop switch, then moves it to absolute targets accepted
//               on a valid/ready command port. Drives PU/DR/MF per channel.
//               Optional macro HOME_TIMEOUT_EN adds a homing step budget
//               (HOME_MAX) that faults a channel whose switch never closes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_axis_stepper_ctrl #(
    parameter int CH       = 6,
    parameter int POS_W    = 10,
    parameter int POS_MAX  = 999,
    parameter int STEP_DIV = 100,
    parameter int HOME_MAX = 1023,
    localparam int c_ch_w  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         Stop,
    input  logic                  home_req,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [c_ch_w-1:0]     cmd_ch,
    input  logic [POS_W-1:0]      cmd_pos,
    output logic [CH-1:0]         PU,
    output logic [CH-1:0]         DR,
    output logic [CH-1:0]         MF,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         homed,
    output logic [CH-1:0]         err,
    output logic [CH*POS_W-1:0]   pos
);

    typedef enum logic [2:0] {
        ST_UNHOMED = 3'd0,
        ST_HOMING  = 3'd1,
        ST_READY   = 3'd2,
        ST_MOVING  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [POS_W-1:0]  c_pos_max  = POS_W'(POS_MAX);
    localparam int                c_div_w    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(STEP_DIV - 1);
    localparam logic [c_ch_w:0]   c_ch_lim   = (c_ch_w + 1)'(CH);
`ifdef HOME_TIMEOUT_EN
    localparam int                c_hc_w     = $clog2(HOME_MAX + 1);
    localparam logic [c_hc_w-1:0] c_home_max = c_hc_w'(HOME_MAX);
`endif

    logic [c_div_w-1:0] r_div;
    logic               w_tick;
    logic [CH-1:0]      r_stop_meta;
    logic [CH-1:0]      r_stop_sync;
    logic [CH-1:0]      w_ready_vec;
    logic [POS_W-1:0]   w_tgt;
    logic               w_ch_ok;

    // Free-running step-tick divider shared by all channels
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)                r_div <= '0;
        else if (r_div == c_div_last) r_div <= '0;
        else                       r_div <= r_div + 1'b1;
    end

    assign w_tick = (r_div == c_div_last);

    // Two-flop synchroniser for the asynchronous home switches
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_meta <= '0;
            r_stop_sync <= '0;
        end else begin
            r_stop_meta <= Stop;
            r_stop_sync <= r_stop_meta;
        end
    end

    // Saturate requested target to the soft limit; home_req outranks a command
    assign w_tgt     = (cmd_pos > c_pos_max) ? c_pos_max : cmd_pos;
    assign w_ch_ok   = ({1'b0, cmd_ch} < c_ch_lim);
    assign cmd_ready = w_ch_ok & w_ready_vec[cmd_ch] & ~home_req;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        state_t           r_state, w_state_nxt;
        logic [POS_W-1:0] r_pos, w_pos_nxt, r_tgt, w_tgt_nxt, w_pos_step;
        logic             r_pu, w_pu_nxt, r_dr, w_dr_nxt, r_arm, w_arm_nxt;
        logic             w_acc, w_home_ok;
`ifdef HOME_TIMEOUT_EN
        logic [c_hc_w-1:0] r_hcnt, w_hcnt_nxt;
`endif

        assign w_acc     = cmd_valid & cmd_ready & (cmd_ch == c_ch_w'(gi));
        assign w_home_ok = (r_state == ST_UNHOMED) | (r_state == ST_READY) |
                           (r_state == ST_FAULT);
        // One step in the current direction, clamped to [0, POS_MAX]
        assign w_pos_step = r_dr ? ((r_pos >= c_pos_max) ? r_pos : r_pos + 1'b1)
                                 : ((r_pos == '0)        ? r_pos : r_pos - 1'b1);

        // Next-state logic: homing, moving, abort on switch, pulse generation
        always_comb begin
            w_state_nxt = r_state;
            w_pos_nxt   = r_pos;
            w_tgt_nxt   = r_tgt;
            w_pu_nxt    = r_pu;
            w_dr_nxt    = r_dr;
            w_arm_nxt   = r_arm;
`ifdef HOME_TIMEOUT_EN
            w_hcnt_nxt  = r_hcnt;
`endif
            // A raised pulse always falls on the following tick
            if (w_tick && r_pu) w_pu_nxt = 1'b0;

            if (home_req && w_home_ok) begin
                w_state_nxt = ST_HOMING;
                w_dr_nxt    = 1'b0;
                w_arm_nxt   = 1'b0;
`ifdef HOME_TIMEOUT_EN
                w_hcnt_nxt  = '0;
`endif
            end else begin
                case (r_state)
                    ST_HOMING: begin
                        if (w_tick) begin
                            if (r_stop_sync[gi]) begin
                                w_state_nxt = ST_READY;
                                w_pos_nxt   = '0;
                                w_pu_nxt    = 1'b0;
                            end else if (!r_pu) begin
                                w_pu_nxt   = 1'b1;
                                w_pos_nxt  = w_pos_step;
`ifdef HOME_TIMEOUT_EN
                                w_hcnt_nxt = r_hcnt + 1'b1;
`endif
                            end
`ifdef HOME_TIMEOUT_EN
                            else if (r_hcnt == c_home_max) begin
                                w_state_nxt = ST_FAULT;
                                w_pu_nxt    = 1'b0;
                            end
`endif
                        end
                    end
                    ST_READY: begin
                        if (w_acc && (w_tgt != r_pos)) begin
                            w_state_nxt = ST_MOVING;
                            w_tgt_nxt   = w_tgt;
                            w_dr_nxt    = (w_tgt > r_pos);
                            w_arm_nxt   = 1'b1;
                        end
                    end
                    ST_MOVING: begin
                        if (r_stop_sync[gi] && !r_dr) begin
                            w_state_nxt = ST_READY;
                            w_pos_nxt   = '0;
                            w_pu_nxt    = 1'b0;
                            w_arm_nxt   = 1'b0;
                        end else if (w_tick) begin
                            // First tick after accept is a DR setup slot
                            if (r_arm) begin
                                w_arm_nxt = 1'b0;
                            end else if (!r_pu) begin
                                w_pu_nxt  = 1'b1;
                                w_pos_nxt = w_pos_step;
                                if (w_pos_step == r_tgt) w_state_nxt = ST_READY;
                            end
                        end
                    end
                    ST_UNHOMED, ST_FAULT: ;
                    default: w_state_nxt = ST_UNHOMED;
                endcase
            end
        end

        // Channel state register
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_UNHOMED;
                r_pos   <= '0;
                r_tgt   <= '0;
                r_pu    <= 1'b0;
                r_dr    <= 1'b0;
                r_arm   <= 1'b0;
`ifdef HOME_TIMEOUT_EN
                r_hcnt  <= '0;
`endif
            end else begin
                r_state <= w_state_nxt;
                r_pos   <= w_pos_nxt;
                r_tgt   <= w_tgt_nxt;
                r_pu    <= w_pu_nxt;
                r_dr    <= w_dr_nxt;
                r_arm   <= w_arm_nxt;
`ifdef HOME_TIMEOUT_EN
                r_hcnt  <= w_hcnt_nxt;
`endif
            end
        end

        assign PU[gi]          = r_pu;
        assign DR[gi]          = r_dr;
        assign MF[gi]          = (r_state == ST_UNHOMED) | (r_state == ST_FAULT);
        assign busy[gi]        = (r_state == ST_HOMING) | (r_state == ST_MOVING);
        assign homed[gi]       = (r_state == ST_READY) | (r_state == ST_MOVING);
        assign w_ready_vec[gi] = (r_state == ST_READY);
        assign pos[gi*POS_W +: POS_W] = r_pos;
`ifdef HOME_TIMEOUT_EN
        assign err[gi]         = (r_state == ST_FAULT);
`endif
    end

`ifndef HOME_TIMEOUT_EN
    assign err = '0;
`endif

endmodule
`default_nettype wire
